// File: rtl/mem_ctrl_pkg.sv
// Shared types and sizing helpers for the memory controller and its write buffer.
// Buffered word addresses are held at their widest (AW up to 32); narrower AW zero-extends.
package mem_ctrl_pkg;

    localparam int WORD_BYTES = 4;
    localparam int WADDR_W    = 30;

    typedef struct packed {
        logic [WADDR_W-1:0] waddr;
        logic [31:0]        data;
    } wbuf_entry_t;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mem_ctrl_wbuf.sv
// Circular write buffer with youngest-match address CAM for store-to-load forwarding.
// Only built when MEM_CTRL_WBUF_EN is defined.
`ifdef MEM_CTRL_WBUF_EN
module mem_ctrl_wbuf
    import mem_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [AW-3:0] push_waddr_i,
    input  logic [31:0]   push_data_i,
    input  logic          pop_i,
    input  logic [AW-3:0] lookup_waddr_i,
    output wbuf_entry_t   head_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          hit_o,
    output logic [31:0]   hit_data_o
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = PW + 1;

    wbuf_entry_t   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] wr_ptr_d;
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] rd_ptr_d;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [PW-1:0] idx_s;
    logic          push_s;
    logic          pop_s;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == {CW{1'b0}});
    assign push_s  = push_i & ~full_o;
    assign pop_s   = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are qualified by count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {WADDR_W'(push_waddr_i), push_data_i};
        end
    end

    // Walk oldest to youngest so the latest matching store overrides earlier ones.
    always_comb begin
        hit_o      = 1'b0;
        hit_data_o = 32'h0000_0000;
        idx_s      = rd_ptr_q;
        for (int k = 0; k < DEPTH; k++) begin
            idx_s = rd_ptr_q + PW'(k);
            if ((CW'(k) < count_q) && (mem_q[idx_s].waddr[AW-3:0] == lookup_waddr_i)) begin
                hit_o      = 1'b1;
                hit_data_o = mem_q[idx_s].data;
            end else begin
                hit_o      = hit_o;
                hit_data_o = hit_data_o;
            end
        end
    end

endmodule
`endif

// File: rtl/mem_ctrl.sv
// CPU memory-controller port to instruction/data RAM. Defining MEM_CTRL_WBUF_EN adds a
// posted write buffer with store-to-load forwarding; otherwise stores pass straight through.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] cpu_instr_addr,
    output logic [31:0]   cpu_instr_data,
    input  logic [AW-1:0] cpu_addr,
    input  logic [31:0]   cpu_wr_data,
    input  logic          cpu_wr,
    output logic [31:0]   cpu_rd_data,
    output logic          cpu_valid,
    input  logic          drain,
    output logic          idle,
    output logic [AW-1:0] ram_instr_addr,
    input  logic [31:0]   ram_instr_data,
    output logic [AW-1:0] ram_rd_addr,
    input  logic [31:0]   ram_rd_data,
    output logic          ram_wr,
    output logic [AW-1:0] ram_wr_addr,
    output logic [31:0]   ram_wr_data,
    input  logic          ram_wr_ready
);

    localparam int OFS_W = $clog2(WORD_BYTES);

    assign ram_instr_addr = cpu_instr_addr;
    assign cpu_instr_data = ram_instr_data;
    assign ram_rd_addr    = cpu_addr;

`ifdef MEM_CTRL_WBUF_EN
    wbuf_entry_t head_s;
    logic        full_s;
    logic        empty_s;
    logic        hit_s;
    logic [31:0] hit_data_s;
    logic        cpu_valid_s;
    logic        push_s;
    logic        ram_wr_s;
    logic        pop_s;
    logic        drain_hold_q;
    logic        drain_hold_d;
    logic        fwd_hit_q;
    logic        fwd_hit_d;
    logic [31:0] fwd_data_q;
    logic [31:0] fwd_data_d;

    assign cpu_valid_s = ~full_s & ~drain_hold_q;
    assign push_s      = cpu_wr & cpu_valid_s;
    // The head is held back during reset so a discarded entry never reaches RAM.
    assign ram_wr_s    = ~empty_s & ~rst;
    assign pop_s       = ram_wr_s & ram_wr_ready;

    mem_ctrl_wbuf #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_wbuf (
        .clk            (clk),
        .rst            (rst),
        .push_i         (push_s),
        .push_waddr_i   (cpu_addr[AW-1:OFS_W]),
        .push_data_i    (cpu_wr_data),
        .pop_i          (pop_s),
        .lookup_waddr_i (cpu_addr[AW-1:OFS_W]),
        .head_o         (head_s),
        .full_o         (full_s),
        .empty_o        (empty_s),
        .hit_o          (hit_s),
        .hit_data_o     (hit_data_s)
    );

    // Drain hold and forwarding next-state.
    always_comb begin
        drain_hold_d = drain_hold_q;
        fwd_hit_d    = 1'b0;
        fwd_data_d   = fwd_data_q;
        if (drain) begin
            drain_hold_d = 1'b1;
        end else if (empty_s) begin
            drain_hold_d = 1'b0;
        end else begin
            drain_hold_d = drain_hold_q;
        end
        if (~cpu_wr & hit_s) begin
            fwd_hit_d  = 1'b1;
            fwd_data_d = hit_data_s;
        end else begin
            fwd_hit_d  = 1'b0;
            fwd_data_d = fwd_data_q;
        end
    end

    // Drain hold and forwarding registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            drain_hold_q <= 1'b0;
            fwd_hit_q    <= 1'b0;
            fwd_data_q   <= 32'h0000_0000;
        end else begin
            drain_hold_q <= drain_hold_d;
            fwd_hit_q    <= fwd_hit_d;
            fwd_data_q   <= fwd_data_d;
        end
    end

    assign cpu_valid   = cpu_valid_s;
    assign idle        = empty_s;
    assign ram_wr      = ram_wr_s;
    assign ram_wr_addr = {head_s.waddr[AW-3:0], {OFS_W{1'b0}}};
    assign ram_wr_data = head_s.data;
    assign cpu_rd_data = fwd_hit_q ? fwd_data_q : ram_rd_data;
`else
    logic unused_s;
    assign unused_s    = ^{clk, rst, drain};

    assign ram_wr      = cpu_wr;
    assign ram_wr_addr = {cpu_addr[AW-1:OFS_W], {OFS_W{1'b0}}};
    assign ram_wr_data = cpu_wr_data;
    assign cpu_valid   = ~cpu_wr | ram_wr_ready;
    assign cpu_rd_data = ram_rd_data;
    assign idle        = 1'b1;
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: RAM model plus an architectural-memory reference.
// Honours MEM_CTRL_WBUF_EN to select the buffered or pass-through expectations.
module tb_mem_ctrl;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int MW    = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] cpu_instr_addr;
    logic [31:0]   cpu_instr_data;
    logic [AW-1:0] cpu_addr;
    logic [31:0]   cpu_wr_data;
    logic          cpu_wr;
    logic [31:0]   cpu_rd_data;
    logic          cpu_valid;
    logic          drain;
    logic          idle;
    logic [AW-1:0] ram_instr_addr;
    logic [31:0]   ram_instr_data;
    logic [AW-1:0] ram_rd_addr;
    logic [31:0]   ram_rd_data;
    logic          ram_wr;
    logic [AW-1:0] ram_wr_addr;
    logic [31:0]   ram_wr_data;
    logic          ram_wr_ready;

    always #5 clk = ~clk;

    mem_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .cpu_instr_addr (cpu_instr_addr),
        .cpu_instr_data (cpu_instr_data),
        .cpu_addr       (cpu_addr),
        .cpu_wr_data    (cpu_wr_data),
        .cpu_wr         (cpu_wr),
        .cpu_rd_data    (cpu_rd_data),
        .cpu_valid      (cpu_valid),
        .drain          (drain),
        .idle           (idle),
        .ram_instr_addr (ram_instr_addr),
        .ram_instr_data (ram_instr_data),
        .ram_rd_addr    (ram_rd_addr),
        .ram_rd_data    (ram_rd_data),
        .ram_wr         (ram_wr),
        .ram_wr_addr    (ram_wr_addr),
        .ram_wr_data    (ram_wr_data),
        .ram_wr_ready   (ram_wr_ready)
    );

    typedef struct {
        logic [7:0]  w;
        logic [31:0] d;
    } st_t;

    logic [31:0] ram_mem [MW];
    logic [31:0] arch    [MW];
`ifdef MEM_CTRL_WBUF_EN
    st_t         pend[$];
    logic        hold;
`endif
    logic        chk_en;
    logic        ld_pend;
    logic [31:0] ld_exp;
    int          err_cnt;
    int          chk_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: check outputs at negedge, then advance RAM and reference at posedge.
    task automatic step();
        logic [7:0]    w;
        logic          exp_valid;
        logic          exp_wr;
        logic          exp_idle;
        logic [AW-1:0] exp_waddr;
        logic [31:0]   exp_wdata;
        logic          push;
        logic          s_wr;
        logic [AW-1:0] s_waddr;
        logic [31:0]   s_wdata;
        logic [31:0]   rd_v;
        logic [31:0]   in_v;
        @(negedge clk);
        w = cpu_addr[9:2];
`ifdef MEM_CTRL_WBUF_EN
        exp_valid = (pend.size() != DEPTH) && !hold;
        exp_wr    = (pend.size() != 0) && !rst;
        exp_idle  = (pend.size() == 0);
        exp_waddr = {AW{1'b0}};
        exp_wdata = 32'h0;
        if (pend.size() != 0) begin
            exp_waddr = AW'({pend[0].w, 2'b00});
            exp_wdata = pend[0].d;
        end
`else
        exp_valid = !cpu_wr || ram_wr_ready;
        exp_wr    = cpu_wr;
        exp_idle  = 1'b1;
        exp_waddr = {cpu_addr[AW-1:2], 2'b00};
        exp_wdata = cpu_wr_data;
`endif
        if (chk_en) begin
            check("cpu_valid", cpu_valid, exp_valid);
            check("ram_wr", ram_wr, exp_wr);
            check("idle", idle, exp_idle);
            check("instr_data", cpu_instr_data, ram_instr_data);
            check("instr_addr", ram_instr_addr, cpu_instr_addr);
            check("rd_addr", ram_rd_addr, cpu_addr);
            if (exp_wr) begin
                check("wr_addr", ram_wr_addr, exp_waddr);
                check("wr_data", ram_wr_data, exp_wdata);
            end
            if (ld_pend) check("rd_data", cpu_rd_data, ld_exp);
        end
        push    = cpu_wr && exp_valid && !rst;
        s_wr    = ram_wr && ram_wr_ready;
        s_waddr = ram_wr_addr;
        s_wdata = ram_wr_data;
        @(posedge clk);
        rd_v = ram_mem[w];
        in_v = ram_mem[cpu_instr_addr[9:2]];
        if (s_wr) ram_mem[s_waddr[9:2]] = s_wdata;
        ram_rd_data    = rd_v;
        ram_instr_data = in_v;
        ld_pend = chk_en && !cpu_wr;
        ld_exp  = rst ? rd_v : arch[w];
        if (rst) begin
`ifdef MEM_CTRL_WBUF_EN
            pend.delete();
            hold = 1'b0;
`endif
            arch = ram_mem;
        end else begin
`ifdef MEM_CTRL_WBUF_EN
            hold = drain || (hold && pend.size() != 0);
            if (exp_wr && ram_wr_ready) void'(pend.pop_front());
            if (push) pend.push_back('{w: w, d: cpu_wr_data});
`endif
            if (push) arch[w] = cpu_wr_data;
        end
        #1;
    endtask

    task automatic drv(input logic r, input logic wr, input logic [AW-1:0] a,
                       input logic [31:0] d, input logic rdy, input logic dr);
        rst            = r;
        cpu_wr         = wr;
        cpu_addr       = a;
        cpu_wr_data    = d;
        ram_wr_ready   = rdy;
        drain          = dr;
        cpu_instr_addr = AW'({$urandom_range(0, MW - 1), 2'b00});
        step();
    endtask

    initial begin
        int mism;
        err_cnt = 0;
        chk_cnt = 0;
        chk_en  = 1'b0;
        ld_pend = 1'b0;
        ld_exp  = 32'h0;
`ifdef MEM_CTRL_WBUF_EN
        hold = 1'b0;
`endif
        for (int i = 0; i < MW; i++) ram_mem[i] = (i * 32'h0101_0101) ^ 32'h5A5A_0000;
        arch           = ram_mem;
        ram_rd_data    = 32'h0;
        ram_instr_data = 32'h0;

        // reset, then idle
        drv(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk_en = 1'b1;
        drv(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        drv(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        drv(1'b0, 1'b0, 32'h4, 32'h0, 1'b0, 1'b0);

        // fill to capacity under backpressure, then a refused fifth store
        for (int i = 0; i < 5; i++)
            drv(1'b0, 1'b1, 32'h100 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) drv(1'b0, 1'b0, 32'h104, 32'h0, 1'b1, 1'b0);

        // same-address stores, youngest forwarded, including while heads pop
        drv(1'b0, 1'b1, 32'h40, 32'h0000_AAAA, 1'b0, 1'b0);
        drv(1'b0, 1'b1, 32'h43, 32'h0000_BBBB, 1'b0, 1'b0);
        drv(1'b0, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0);
        drv(1'b0, 1'b0, 32'h41, 32'h0, 1'b1, 1'b0);
        drv(1'b0, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0);
        drv(1'b0, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0);

        // drain pulse with three buffered stores; stores refused until empty
        for (int i = 0; i < 3; i++)
            drv(1'b0, 1'b1, 32'h200 + 32'(4 * i), 32'hD000_0000 + 32'(i), 1'b0, 1'b0);
        drv(1'b0, 1'b0, 32'h204, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++)
            drv(1'b0, 1'b1, 32'h220 + 32'(4 * i), 32'hE000_0000 + 32'(i), 1'b1, 1'b0);

        // randomized traffic on a small word window to provoke forwarding hits
        for (int n = 0; n < 3000; n++) begin
            drv(($urandom_range(0, 199) == 0),
                ($urandom_range(0, 9) < 4),
                AW'({$urandom_range(16, 31), 2'($urandom_range(0, 3))}),
                $urandom(),
                ($urandom_range(0, 9) < 6),
                ($urandom_range(0, 29) == 0));
        end

        // final drain, bounded, then RAM must equal the architectural memory
        drv(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        for (int n = 0; n < 20 && !idle; n++) drv(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        drv(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("idle_after_drain", idle, 1'b1);
        mism = 0;
        for (int i = 0; i < MW; i++) if (ram_mem[i] !== arch[i]) mism++;
        check("ram_vs_arch", 64'(mism), 64'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller between the CPU's memory-controller port and the external instruction/data RAM. It passes instruction fetches straight through and posts CPU data writes into a small write buffer. The buffer drains to the RAM write port under `ram_wr_ready` backpressure. Data reads return buffered (not-yet-written) data via store-to-load forwarding, so the CPU sees a one-cycle, always-coherent data read. It drives the CPU's `mem_valid` (`cpu_valid`), which stalls only on writes.

## Interface
Parameters:
- `DEPTH`, 4: write-buffer entries; power of 2, 2..16.
- `AW`, 32: byte-address width; word address is `[AW-1:2]`.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `cpu_instr_addr`  in  AW  fetch address.
- `cpu_instr_data`  out  32  fetch data, = `ram_instr_data`.
- `cpu_addr`  in  AW  data address (read every cycle `cpu_wr`=0).
- `cpu_wr_data`  in  32  store data.
- `cpu_wr`  in  1  store request.
- `cpu_rd_data`  out  32  load data, 1 cycle after `cpu_addr`.
- `cpu_valid`  out  1  store accepted this cycle / controller ready.
- `drain`  in  1  request: stop accepting stores until buffer empty.
- `idle`  out  1  buffer empty.
- `ram_instr_addr`  out  AW  = `cpu_instr_addr`.
- `ram_instr_data`  in  32  sync read, 1-cycle latency.
- `ram_rd_addr`  out  AW  = `cpu_addr`.
- `ram_rd_data`  in  32  sync read, 1-cycle latency.
- `ram_wr`  out  1  head entry valid.
- `ram_wr_addr`  out  AW  head entry address (low 2 bits 0).
- `ram_wr_data`  out  32  head entry data.
- `ram_wr_ready`  in  1  RAM accepts write this cycle.

## Operation
- Buffer is a circular FIFO with `wr_ptr`, `rd_ptr`, and `count` (0..DEPTH).
- Push on `cpu_wr & cpu_valid`. Pop on `ram_wr & ram_wr_ready`. Push and pop in the same cycle leave `count` unchanged.
- `cpu_valid = (count != DEPTH) & ~drain_hold`. Full blocks a push even when a pop happens in the same cycle.
- `drain_hold` sets on `drain` and clears when `count`==0. While it is set, stores are refused; reads still work.
- Forwarding: when `cpu_wr`=0, compare `cpu_addr[AW-1:2]` against every valid entry.
  - Compare against pre-edge contents, including a head being popped that cycle.
  - On a match, the youngest entry wins; register `fwd_hit` and `fwd_data`.
  - `cpu_rd_data = fwd_hit ? fwd_data : ram_rd_data`.
- Stores are word-only. `cpu_addr[1:0]` is ignored and `ram_wr_addr[1:0]` is driven 0.
- The instruction port does not see buffered stores. Software must `drain` before executing freshly written code.

## Timing
- Reset values:
  - `count`, pointers, `fwd_hit`, and `drain_hold` are 0.
  - `cpu_valid`=1, `idle`=1, `ram_wr`=0.
  - `cpu_rd_data` tracks `ram_rd_data`.
- Store visible on `ram_wr` the cycle after acceptance. With `ram_wr_ready` held high, throughput is 1 store/cycle.
- Load latency is 1 cycle, identical for hit and miss.
- A store at edge N followed by a load of the same address in cycle N+1 returns the stored data in cycle N+2.
- Reset mid-operation discards all buffered stores. No RAM write is issued in the reset cycle.
- `ram_wr_ready` asserted while `ram_wr`=0 has no effect.

## Configuration
- `MEM_CTRL_WBUF_EN` defined: buffer and forwarding as above.
- Not defined: no storage. Stores pass straight through:
  - `ram_wr = cpu_wr`; address and data are combinational from the CPU side.
  - `cpu_valid = ~cpu_wr | ram_wr_ready`.
  - `cpu_rd_data = ram_rd_data`.
  - `idle`=1 always; `drain` ignored.

## Structure
- `mem_ctrl_pkg`:
  - `wbuf_entry_t` = {word address `[AW-3:0]`, data `[31:0]`}.
  - `WORD_BYTES`=4.
  - A `clog2`-based pointer-width localparam helper.
- Sub-module `mem_ctrl_wbuf` contains storage, pointers, count, and the youngest-match CAM. It outputs head, full, empty, `hit`, and `hit_data`.
- The top level holds `drain_hold`, the forward registers, and the output muxing.

## Test plan
- Reset, then idle → `cpu_valid`=1, `idle`=1, `ram_wr`=0.
- Stores to 0x100/0x104/0x108/0x10C with `ram_wr_ready`=0 → 4 accepted. Fifth store to 0x110 sees `cpu_valid`=0 (DEPTH=4).
- Release `ram_wr_ready` → RAM writes appear in order 0x100..0x10C, one per cycle, then `idle`=1.
- Store 0xAAAA to 0x40, then store 0xBBBB to 0x40, then load 0x40 with `ram_wr_ready`=0 → `cpu_rd_data`=0xBBBB next cycle.
- Load 0x40 in the same cycle the 0x40 head pops → forwarded value returned, not stale RAM data.
- `drain` pulse with 3 entries buffered → stores refused until 3 pops complete. `cpu_valid` returns to 1 the cycle after `count`==0.
